// File: rtl/ttl_bus_driver_arb.sv
// Shared-bus driver: CHANNELS active-low-enabled sources arbitrated onto one
// registered WIDTH-bit bus, with programmable dead cycles between owners.
module ttl_bus_driver_arb #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 4,
  parameter int TURNAROUND = 1,
  parameter int LATCH_MODE = 0,
  localparam int OWNER_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      sysclk,
  input  logic                      sys_rst,
  input  logic [CHANNELS-1:0]       g_n,
  input  logic [CHANNELS*WIDTH-1:0] a,
  output logic [WIDTH-1:0]          y,
  output logic                      oe,
  output logic [OWNER_W-1:0]        owner,
  output logic                      waiting
);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  state_t               state, state_d;
  logic [WIDTH-1:0]     y_d;
  logic                 oe_d, waiting_d;
  logic [OWNER_W-1:0]   owner_d;
  logic [3:0]           cnt, cnt_d;

  logic [CHANNELS-1:0]  req;
  logic                 any_req;
  logic [OWNER_W-1:0]   win;
  logic [WIDTH-1:0]     win_data, own_data;
  logic                 own_req, win_others, own_others;

  assign req     = ~g_n;
  assign any_req = |req;

  // Lowest index wins; scanning high-to-low lets the last hit be the winner.
  always_comb begin
    win        = '0;
    win_data   = '0;
    own_data   = '0;
    own_req    = 1'b0;
    win_others = 1'b0;
    own_others = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (req[k]) win = OWNER_W'(k);
    end
    for (int k = 0; k < CHANNELS; k++) begin
      if (win == OWNER_W'(k)) win_data = a[k*WIDTH +: WIDTH];
      else if (req[k])        win_others = 1'b1;
      if (owner == OWNER_W'(k)) begin
        own_data = a[k*WIDTH +: WIDTH];
        own_req  = req[k];
      end else if (req[k]) begin
        own_others = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state;
    y_d       = '0;
    oe_d      = 1'b0;
    owner_d   = owner;
    waiting_d = 1'b0;
    cnt_d     = cnt;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_d   = DRIVE;
          owner_d   = win;
          oe_d      = 1'b1;
          y_d       = win_data;
          waiting_d = win_others;
        end
      end
      DRIVE: begin
        if (own_req) begin
          oe_d      = 1'b1;
          y_d       = (LATCH_MODE != 0) ? y : own_data;
          waiting_d = own_others;
        end else if (TURNAROUND == 0) begin
          // Zero dead time: hand over on the release edge itself.
          if (any_req) begin
            owner_d   = win;
            oe_d      = 1'b1;
            y_d       = win_data;
            waiting_d = win_others;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = TURN;
          cnt_d   = 4'(TURNAROUND - 1);
        end
      end
      TURN: begin
        if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else if (any_req) begin
          state_d   = DRIVE;
          owner_d   = win;
          oe_d      = 1'b1;
          y_d       = win_data;
          waiting_d = win_others;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= IDLE;
      y       <= '0;
      oe      <= 1'b0;
      owner   <= '0;
      waiting <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_d;
      y       <= y_d;
      oe      <= oe_d;
      owner   <= owner_d;
      waiting <= waiting_d;
      cnt     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ttl_bus_driver_arb.sv
// Directed bench: four instances cover default, zero, long turnaround and latch mode.
module tb_ttl_bus_driver_arb;

  logic       sysclk = 1'b0;
  logic       sys_rst;
  logic [1:0] g0, g1, g2, g3;
  logic [7:0] a0, a1, a2, a3;
  logic [3:0] y0, y1, y2, y3;
  logic       oe0, oe1, oe2, oe3;
  logic       ow0, ow1, ow2, ow3;
  logic       w0, w1, w2, w3;
  int checks = 0;
  int failures = 0;

  always #5 sysclk = ~sysclk;

  ttl_bus_driver_arb #(.CHANNELS(2), .WIDTH(4), .TURNAROUND(1), .LATCH_MODE(0)) u_def (
    .sysclk(sysclk), .sys_rst(sys_rst), .g_n(g0), .a(a0),
    .y(y0), .oe(oe0), .owner(ow0), .waiting(w0));
  ttl_bus_driver_arb #(.CHANNELS(2), .WIDTH(4), .TURNAROUND(0), .LATCH_MODE(0)) u_ta0 (
    .sysclk(sysclk), .sys_rst(sys_rst), .g_n(g1), .a(a1),
    .y(y1), .oe(oe1), .owner(ow1), .waiting(w1));
  ttl_bus_driver_arb #(.CHANNELS(2), .WIDTH(4), .TURNAROUND(3), .LATCH_MODE(0)) u_ta3 (
    .sysclk(sysclk), .sys_rst(sys_rst), .g_n(g2), .a(a2),
    .y(y2), .oe(oe2), .owner(ow2), .waiting(w2));
  ttl_bus_driver_arb #(.CHANNELS(2), .WIDTH(4), .TURNAROUND(1), .LATCH_MODE(1)) u_lat (
    .sysclk(sysclk), .sys_rst(sys_rst), .g_n(g3), .a(a3),
    .y(y3), .oe(oe3), .owner(ow3), .waiting(w3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  initial begin
    sys_rst = 1'b1;
    g0 = 2'b00; g1 = 2'b00; g2 = 2'b00; g3 = 2'b00;
    a0 = 8'h00; a1 = 8'h00; a2 = 8'h00; a3 = 8'h00;
    tick(); tick();
    chk("rst_y",  {28'd0, y0}, 32'h0);
    chk("rst_oe", {31'd0, oe0}, 32'h0);
    chk("rst_ow", {31'd0, ow0}, 32'h0);
    chk("rst_w",  {31'd0, w0}, 32'h0);
    chk("rst_oe_ta3", {31'd0, oe2}, 32'h0);
    g0 = 2'b11; g1 = 2'b11; g2 = 2'b11; g3 = 2'b11;
    sys_rst = 1'b0;
    tick();
    chk("idle_oe", {31'd0, oe0}, 32'h0);

    // single grant, follow mode
    g0 = 2'b10; a0 = 8'h0A;
    tick();
    chk("grant_oe", {31'd0, oe0}, 32'h1);
    chk("grant_y",  {28'd0, y0}, 32'hA);
    chk("grant_ow", {31'd0, ow0}, 32'h0);
    chk("grant_w",  {31'd0, w0}, 32'h0);
    a0 = 8'h05;
    tick();
    chk("follow_y", {28'd0, y0}, 32'h5);
    g0 = 2'b11;
    tick();
    chk("rel_oe", {31'd0, oe0}, 32'h0);
    chk("rel_y",  {28'd0, y0}, 32'h0);
    tick();
    chk("back_idle_oe", {31'd0, oe0}, 32'h0);

    // priority and TURNAROUND=1
    g0 = 2'b00; a0 = 8'hC3;
    tick();
    chk("prio_ow", {31'd0, ow0}, 32'h0);
    chk("prio_y",  {28'd0, y0}, 32'h3);
    chk("prio_w",  {31'd0, w0}, 32'h1);
    g0 = 2'b01;
    tick();
    chk("turn_oe", {31'd0, oe0}, 32'h0);
    chk("turn_y",  {28'd0, y0}, 32'h0);
    chk("turn_w",  {31'd0, w0}, 32'h0);
    tick();
    chk("sw_ow", {31'd0, ow0}, 32'h1);
    chk("sw_oe", {31'd0, oe0}, 32'h1);
    chk("sw_y",  {28'd0, y0}, 32'hC);

    // TURNAROUND=0 direct handover
    g1 = 2'b00; a1 = 8'hC3;
    tick();
    chk("ta0_ow0", {31'd0, ow1}, 32'h0);
    chk("ta0_y0",  {28'd0, y1}, 32'h3);
    chk("ta0_w0",  {31'd0, w1}, 32'h1);
    g1 = 2'b01;
    tick();
    chk("ta0_ow1", {31'd0, ow1}, 32'h1);
    chk("ta0_y1",  {28'd0, y1}, 32'hC);
    chk("ta0_oe1", {31'd0, oe1}, 32'h1);
    chk("ta0_w1",  {31'd0, w1}, 32'h0);
    g1 = 2'b11;
    tick();
    chk("ta0_idle_oe", {31'd0, oe1}, 32'h0);
    chk("ta0_idle_y",  {28'd0, y1}, 32'h0);

    // TURNAROUND=3, late requester during the dead time
    g2 = 2'b10; a2 = 8'hD6;
    tick();
    chk("ta3_oe", {31'd0, oe2}, 32'h1);
    chk("ta3_y",  {28'd0, y2}, 32'h6);
    g2 = 2'b11;
    tick();
    chk("ta3_dead1", {31'd0, oe2}, 32'h0);
    g2 = 2'b01;
    tick();
    chk("ta3_dead2", {31'd0, oe2}, 32'h0);
    tick();
    chk("ta3_dead3", {31'd0, oe2}, 32'h0);
    chk("ta3_dead3_y", {28'd0, y2}, 32'h0);
    tick();
    chk("ta3_ow", {31'd0, ow2}, 32'h1);
    chk("ta3_oe_back", {31'd0, oe2}, 32'h1);
    chk("ta3_y_back", {28'd0, y2}, 32'hD);

    // LATCH_MODE=1 holds the grant-time value
    g3 = 2'b10; a3 = 8'h09;
    tick();
    chk("lat_y0", {28'd0, y3}, 32'h9);
    a3 = 8'h02;
    tick();
    chk("lat_y1", {28'd0, y3}, 32'h9);
    tick();
    chk("lat_y2", {28'd0, y3}, 32'h9);
    g3 = 2'b11;
    tick();
    chk("lat_rel_y",  {28'd0, y3}, 32'h0);
    chk("lat_rel_oe", {31'd0, oe3}, 32'h0);

    // async reset mid-cycle while u_def drives channel 1
    chk("pre_rst_oe", {31'd0, oe0}, 32'h1);
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_oe", {31'd0, oe0}, 32'h0);
    chk("arst_y",  {28'd0, y0}, 32'h0);
    chk("arst_ow", {31'd0, ow0}, 32'h0);
    g0 = 2'b10; a0 = 8'h07;
    #1 sys_rst = 1'b0;
    tick();
    chk("post_rst_oe", {31'd0, oe0}, 32'h1);
    chk("post_rst_y",  {28'd0, y0}, 32'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ttl_bus_driver_arb.md
Name: ttl_bus_driver_arb

Overview:
- Parametrised successor to the octal 3-state buffer model: CHANNELS sources of WIDTH bits share one output bus.
- Each source has an active-low enable (G_n style). The block registers the bus, grants exactly one driver at a time, and inserts programmable turnaround (dead) cycles between owners.
- Sits in front of shared internal buses where several TTL buffer groups previously drove the same net.
- High-impedance is modelled as 0, with an explicit oe output, consistent with the existing TTL buffer models.

Parameters:
- CHANNELS, 2: number of source channels (>=1).
- WIDTH, 4: bits per channel (>=1).
- TURNAROUND, 1: dead cycles (oe=0) between release and next grant; legal range 0..15.
- LATCH_MODE, 0: 0 = bus follows granted input every cycle; 1 = data captured at grant and held until release.
- OWNER_W is derived, not a parameter: max(1, clog2(CHANNELS)).

Ports:
- sysclk  input  1  system clock; all state changes on rising edge.
- sys_rst  input  1  reset, asynchronous, active-high.
- g_n  input  CHANNELS  per-channel output-enable request, active low.
- a  input  CHANNELS*WIDTH  channel data; channel k occupies a[k*WIDTH +: WIDTH].
- y  output  WIDTH  registered bus value; 0 when not driving.
- oe  output  1  registered; 1 while a channel owns the bus.
- owner  output  OWNER_W  registered index of current/last owner.
- waiting  output  1  registered; 1 while in DRIVE and any non-owner g_n is low.

Behaviour:
- Reset (async, immediate, no clock needed):
  - state=IDLE, y=0, oe=0, owner=0, waiting=0, turn counter=0.
- States: IDLE, DRIVE, TURN. Arbitration is fixed priority: the lowest index with g_n low wins.
- IDLE:
  - At each edge, if any g_n bit is low, grant winner k: state->DRIVE, owner<=k, oe<=1, y<=a[k].
  - Otherwise y=0, oe=0.
  - Latency: g_n low sampled at edge n gives y valid after edge n, i.e. one cycle.
- DRIVE, owner k, g_n[k] still low:
  - LATCH_MODE=0: y<=a[k] every edge.
  - LATCH_MODE=1: y holds the value captured at grant.
  - No preemption; higher-priority requests wait.
  - waiting<=1 if any g_n[j]=0 with j!=k, else 0.
- DRIVE, g_n[k] high at an edge (release):
  - TURNAROUND=0: re-arbitrate at the same edge.
    - If a request is present, switch owner directly; oe stays 1; y<=new channel data.
    - Otherwise go IDLE with oe<=0, y<=0.
  - TURNAROUND>0: state->TURN, oe<=0, y<=0, counter<=TURNAROUND-1. owner keeps its last value.
- TURN:
  - oe=0, y=0; g_n is ignored except at the final edge.
  - While counter!=0, decrement.
  - At the edge where counter==0, arbitrate as in IDLE: grant gives DRIVE, else IDLE.
  - Result: exactly TURNAROUND cycles with oe=0 between owners.
  - The previous owner re-asserting g_n during TURN counts as a fresh request at normal priority.
- waiting is 0 in IDLE and TURN.
- CHANNELS=1: owner is tied to 0; waiting is always 0.
- A reset during DRIVE or TURN drops the bus immediately. After reset deasserts, the next edge arbitrates from IDLE.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold sys_rst=1 with g_n=2'b00 -> y=0, oe=0, owner=0, waiting=0. Assert sys_rst mid-cycle during DRIVE -> y/oe go to 0 before the next sysclk edge.
- Single grant (defaults): g_n=2'b10, channel 0 data=4'hA sampled at edge n -> after edge n: oe=1, y=4'hA, owner=0. Change channel 0 to 4'h5 -> y=4'h5 one edge later.
- Priority and turnaround (TURNAROUND=1): from IDLE, g_n=2'b00, a0=4'h3, a1=4'hC -> owner=0, y=4'h3, waiting=1. Release g_n[0]:
  - next cycle oe=0, y=0, waiting=0;
  - following cycle owner=1, oe=1, y=4'hC.
- TURNAROUND=0: same stimulus -> on the release edge owner becomes 1, y=4'hC, and oe never drops.
- TURNAROUND=3: release with no other requester, then g_n[1]=0 during TURN -> oe=0 for exactly 3 cycles, then owner=1 and oe=1.
- LATCH_MODE=1: grant channel 0 with a0=4'h9, then drive a0=4'h2 -> y stays 4'h9 until release, then 0.
